// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//
// Contents:
//   NIBBLE_W - width of one adder pass, in bits.
//   state_t  - controller state encoding (IDLE, RUN, DONE).
//   clog2    - ceiling log2, never less than 1. Used to size the nibble counter.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // A single-nibble configuration would otherwise produce a zero-width counter,
  // so the result is clamped to at least one bit.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >>> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// Four-bit ripple-carry adder. This is the single shared datapath adder that
// the serial controller time-multiplexes.
//
// Ports:
//   in_x, in_y - 4-bit addends
//   in_c       - carry-in
//   out_s      - 4-bit sum
//   out_c      - carry-out of bit 3
module Ripple_Carry_Adder_4bit (
  input  logic [3:0] in_x,
  input  logic [3:0] in_y,
  input  logic       in_c,
  output logic [3:0] out_s,
  output logic       out_c
);

  logic c1;
  logic c2;
  logic c3;

  // One full adder per bit. The carries are named explicitly so that the
  // ripple chain reads as separate nets, not as a self-referencing vector.
  always_comb begin
    out_s[0] = in_x[0] ^ in_y[0] ^ in_c;
    c1       = (in_x[0] & in_y[0]) | (in_c & (in_x[0] ^ in_y[0]));
    out_s[1] = in_x[1] ^ in_y[1] ^ c1;
    c2       = (in_x[1] & in_y[1]) | (c1 & (in_x[1] ^ in_y[1]));
    out_s[2] = in_x[2] ^ in_y[2] ^ c2;
    c3       = (in_x[2] & in_y[2]) | (c2 & (in_x[2] ^ in_y[2]));
    out_s[3] = in_x[3] ^ in_y[3] ^ c3;
    out_c    = (in_x[3] & in_y[3]) | (c3 & (in_x[3] ^ in_y[3]));
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract controller. It performs a WIDTH-bit add or
// subtract through one shared 4-bit ripple-carry adder, one nibble per clock,
// starting with the least significant nibble.
//
// Ports:
//   in_clk    - rising-edge clock
//   in_rst_n  - asynchronous active-low reset
//   in_start  - request; only taken in IDLE or DONE
//   in_sub    - 0 = x + y + in_c, 1 = x - y
//   in_x      - operand x (WIDTH bits)
//   in_y      - operand y (WIDTH bits)
//   in_c      - carry-in for add; ignored for subtract
//   out_s     - registered result; holds until the next completion
//   out_c     - carry-out of the MSB; for subtract, 1 means no borrow
//   out_v     - signed two's-complement overflow
//   out_busy  - high while an operation is in progress
//   out_done  - one-cycle pulse when out_s/out_c/out_v are updated
module nibble_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_start,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_c,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             out_v,
  output logic             out_busy,
  output logic             out_done
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

  state_t                  state;
  state_t                  state_next;
  logic [WIDTH-1:0]        x_r;
  logic [WIDTH-1:0]        y_r;
  logic [WIDTH-NIBBLE_W-1:0] sum_sr;
  logic                    carry_r;
  logic [CNT_W-1:0]        nib_idx;
  logic                    accept;
  logic                    last_pass;
  logic [NIBBLE_W-1:0]     x_nib;
  logic [NIBBLE_W-1:0]     y_nib;
  logic [NIBBLE_W-1:0]     add_s;
  logic                    add_c;
  logic [WIDTH-1:0]        sum_full;

  assign accept    = in_start && ((state == IDLE) || (state == DONE));
  assign last_pass = (state == RUN) && (nib_idx == LAST_IDX);
  assign x_nib     = x_r[nib_idx * NIBBLE_W +: NIBBLE_W];
  assign y_nib     = y_r[nib_idx * NIBBLE_W +: NIBBLE_W];

  // The new nibble enters at the top and earlier nibbles move down. After the
  // last pass the complete result is already in LSB-first order.
  assign sum_full  = {add_s, sum_sr};

  Ripple_Carry_Adder_4bit u_adder (
    .in_x  (x_nib),
    .in_y  (y_nib),
    .in_c  (carry_r),
    .out_s (add_s),
    .out_c (add_c)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // busy and done decode only the state register, so no input reaches an
  // output through combinational logic.
  always_comb begin
    state_next = state;
    out_busy   = 1'b0;
    out_done   = 1'b0;
    case (state)
      IDLE: begin
        if (in_start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        out_busy = 1'b1;
        if (nib_idx == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_done   = 1'b1;
        state_next = in_start ? RUN : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Subtract is x + ~y + 1. The operand is inverted once when it is latched,
  // and the +1 is fed in as the initial carry. Overflow is then judged against
  // the effective (inverted) operand.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      x_r     <= '0;
      y_r     <= '0;
      sum_sr  <= '0;
      carry_r <= 1'b0;
      nib_idx <= '0;
      out_s   <= '0;
      out_c   <= 1'b0;
      out_v   <= 1'b0;
    end else if (accept) begin
      x_r     <= in_x;
      y_r     <= in_sub ? ~in_y : in_y;
      carry_r <= in_sub ? 1'b1 : in_c;
      nib_idx <= '0;
    end else if (state == RUN) begin
      sum_sr  <= sum_full[WIDTH-1:NIBBLE_W];
      carry_r <= add_c;
      if (last_pass) begin
        nib_idx <= '0;
        out_s   <= sum_full;
        out_c   <= add_c;
        out_v   <= (x_r[WIDTH-1] == y_r[WIDTH-1]) && (add_s[NIBBLE_W-1] != x_r[WIDTH-1]);
      end else begin
        nib_idx <= nib_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH = 16). Expected
// results come from plain integer arithmetic on the operands.
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;

  logic             in_clk = 1'b0;
  logic             in_rst_n = 1'b0;
  logic             in_start = 1'b0;
  logic             in_sub = 1'b0;
  logic [WIDTH-1:0] in_x = '0;
  logic [WIDTH-1:0] in_y = '0;
  logic             in_c = 1'b0;
  logic [WIDTH-1:0] out_s;
  logic             out_c;
  logic             out_v;
  logic             out_busy;
  logic             out_done;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [WIDTH-1:0] held_s = '0;
  logic             held_c = 1'b0;
  logic             held_v = 1'b0;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .in_start (in_start),
    .in_sub   (in_sub),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_c     (in_c),
    .out_s    (out_s),
    .out_c    (out_c),
    .out_v    (out_v),
    .out_busy (out_busy),
    .out_done (out_done)
  );

  always #5 in_clk = ~in_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference arithmetic: the true sum or difference, the carry or no-borrow
  // flag, and overflow found by checking the signed result against the 16-bit range.
  task automatic modelOp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic sub, input logic c,
                         output logic [WIDTH-1:0] s, output logic co, output logic v);
    int sx;
    int sy;
    int r;
    int ux;
    int uy;
    int total;
    sx = $signed(x);
    sy = $signed(y);
    ux = int'(x);
    uy = int'(y);
    if (sub) begin
      total = ux - uy;
      co    = (ux >= uy);
      r     = sx - sy;
    end else begin
      total = ux + uy + (c ? 1 : 0);
      co    = (total > 65535);
      r     = sx + sy + (c ? 1 : 0);
    end
    s = WIDTH'(total & 32'hFFFF);
    v = (r > 32767) || (r < -32768);
  endtask

  task automatic scramble();
    in_x   = WIDTH'($urandom);
    in_y   = WIDTH'($urandom);
    in_sub = 1'($urandom);
    in_c   = 1'($urandom);
  endtask

  // Starts one operation and follows it through every RUN cycle until the DONE
  // cycle. The task returns at the DONE cycle, so an immediately following call
  // makes a back-to-back start.
  task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input logic sub, input logic c, input bit disturb,
                               input string tag);
    logic [WIDTH-1:0] es;
    logic             ec;
    logic             ev;
    modelOp(x, y, sub, c, es, ec, ev);
    in_x     = x;
    in_y     = y;
    in_sub   = sub;
    in_c     = c;
    in_start = 1'b1;
    @(posedge in_clk);
    #1;
    in_start = 1'b0;
    scramble();
    for (int k = 0; k < 4; k++) begin
      checkOutput({tag, ".busy"}, 32'(out_busy), 32'd1);
      checkOutput({tag, ".done_early"}, 32'(out_done), 32'd0);
      if (k == 0 || k == 3) begin
        checkOutput({tag, ".s_held"}, 32'(out_s), 32'(held_s));
        checkOutput({tag, ".cv_held"}, 32'({out_c, out_v}), 32'({held_c, held_v}));
      end
      if (disturb && k == 1) begin
        in_start = 1'b1;
        scramble();
      end else begin
        in_start = 1'b0;
      end
      @(posedge in_clk);
      #1;
    end
    checkOutput({tag, ".done"}, 32'(out_done), 32'd1);
    checkOutput({tag, ".busy_off"}, 32'(out_busy), 32'd0);
    checkOutput({tag, ".s"}, 32'(out_s), 32'(es));
    checkOutput({tag, ".c"}, 32'(out_c), 32'(ec));
    checkOutput({tag, ".v"}, 32'(out_v), 32'(ev));
    held_s = es;
    held_c = ec;
    held_v = ev;
  endtask

  task automatic idleCycles(input int n);
    in_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge in_clk);
      #1;
      checkOutput("idle.busy", 32'(out_busy), 32'd0);
      checkOutput("idle.done", 32'(out_done), 32'd0);
      checkOutput("idle.s_held", 32'(out_s), 32'(held_s));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] ry;
    logic             rsub;
    logic             rc;

    // Check the reset values while reset is asserted.
    #12;
    checkOutput("reset.s", 32'(out_s), 32'd0);
    checkOutput("reset.c", 32'(out_c), 32'd0);
    checkOutput("reset.v", 32'(out_v), 32'd0);
    checkOutput("reset.busy", 32'(out_busy), 32'd0);
    checkOutput("reset.done", 32'(out_done), 32'd0);
    in_rst_n = 1'b1;
    @(posedge in_clk);
    #1;

    // Directed cases from the test plan.
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, "add_basic");
    idleCycles(2);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "add_wrap");
    idleCycles(1);
    applyStimulus(16'h000F, 16'h0000, 1'b0, 1'b1, 1'b0, "add_cin");
    idleCycles(1);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "add_ovf");
    idleCycles(1);
    applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, "sub_ovf");
    idleCycles(1);
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, "sub_borrow");
    idleCycles(1);
    applyStimulus(16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, "sub_cin_ignored");
    idleCycles(1);

    // A start pulse and operand changes during RUN must be ignored. The
    // next operation then starts straight from DONE.
    applyStimulus(16'hA5A5, 16'h1111, 1'b0, 1'b1, 1'b1, "disturb");
    applyStimulus(16'h3C3C, 16'h0F0F, 1'b1, 1'b0, 1'b0, "back_to_back");
    idleCycles(1);

    // Assert reset during the second RUN cycle.
    in_x     = 16'h00FF;
    in_y     = 16'h0101;
    in_sub   = 1'b0;
    in_c     = 1'b0;
    in_start = 1'b1;
    @(posedge in_clk);
    #1;
    in_start = 1'b0;
    @(posedge in_clk);
    #1;
    in_rst_n = 1'b0;
    #1;
    checkOutput("midrst.s", 32'(out_s), 32'd0);
    checkOutput("midrst.c", 32'(out_c), 32'd0);
    checkOutput("midrst.v", 32'(out_v), 32'd0);
    checkOutput("midrst.busy", 32'(out_busy), 32'd0);
    checkOutput("midrst.done", 32'(out_done), 32'd0);
    held_s = '0;
    held_c = 1'b0;
    held_v = 1'b0;
    #2;
    in_rst_n = 1'b1;
    idleCycles(4);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, "after_reset");
    idleCycles(1);

    // Random operations against the reference model.
    for (int i = 0; i < 16; i++) begin
      rx   = WIDTH'($urandom);
      ry   = WIDTH'($urandom);
      rsub = 1'($urandom);
      rc   = 1'($urandom);
      applyStimulus(rx, ry, rsub, rc, bit'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 2) != 0) begin
        idleCycles(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
